// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; multiply/divide operands are held for MUL_DIV_CYCLES.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
    parameter int MUL_DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_operand_1,
    input  logic [31:0] req0_operand_2,
    input  logic [3:0]  req0_control,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_operand_1,
    input  logic [31:0] req1_operand_2,
    input  logic [3:0]  req1_control,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] alu_operand_1,
    output logic [31:0] alu_operand_2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result
);
    localparam logic [3:0] CTRL_MUL   = 4'b0011;
    localparam logic [3:0] CTRL_DIV   = 4'b0100;
    localparam logic [3:0] MULTI_LOAD = 4'(MUL_DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       owner;
    logic [3:0] count;
    logic       grant;
    logic       accept;
    logic [3:0] grant_control;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On contention the requester not served last wins; otherwise the only valid one does.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`else
    assign grant = req1_valid && !req0_valid;
`endif

    assign req0_ready    = (state == IDLE) && req0_valid && !grant;
    assign req1_ready    = (state == IDLE) && req1_valid && grant;
    assign accept        = req0_ready || req1_ready;
    assign grant_control = grant ? req1_control : req0_control;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= 1'b0;
            count         <= 4'd0;
            alu_operand_1 <= 32'd0;
            alu_operand_2 <= 32'd0;
            alu_control   <= 4'b0000;
            rsp_result    <= 32'd0;
            rsp0_valid    <= 1'b0;
            rsp1_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_operand_1 <= grant ? req1_operand_1 : req0_operand_1;
                        alu_operand_2 <= grant ? req1_operand_2 : req0_operand_2;
                        alu_control   <= grant_control;
                        owner         <= grant;
                        count         <= (grant_control == CTRL_MUL || grant_control == CTRL_DIV)
                                         ? MULTI_LOAD : 4'd0;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    // Counter reaching zero marks the last cycle of the multi-cycle path.
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if ((!owner && rsp0_ready) || (owner && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small behavioural ALU model.
// Expected grant order follows ALU_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_alu_share_arbiter;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_MUL = 4'b0011;
    localparam logic [3:0] C_DIV = 4'b0100;
    localparam logic [3:0] C_SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2;
    logic [3:0]  req0_control, req1_control;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result, alu_operand_1, alu_operand_2, alu_result;
    logic [3:0]  alu_control;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.MUL_DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_operand_1(req0_operand_1), .req0_operand_2(req0_operand_2), .req0_control(req0_control),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_operand_1(req1_operand_1), .req1_operand_2(req1_operand_2), .req1_control(req1_control),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2), .alu_control(alu_control),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            C_AND: alu_result = alu_operand_1 & alu_operand_2;
            C_ADD: alu_result = alu_operand_1 + alu_operand_2;
            C_SUB: alu_result = alu_operand_1 - alu_operand_2;
            C_MUL: alu_result = alu_operand_1 * alu_operand_2;
            C_DIV: alu_result = (alu_operand_2 == 32'd0) ? 32'hFFFF_FFFF : alu_operand_1 / alu_operand_2;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] exp_grant;
        int waited;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_grant = 4'b1010;
`else
        exp_grant = 4'b0000;
`endif
        rst = 1'b1;
        req0_valid = 1'b0; req0_operand_1 = '0; req0_operand_2 = '0; req0_control = '0;
        req1_valid = 1'b0; req1_operand_1 = '0; req1_operand_2 = '0; req1_control = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); step();

        // Reset state
        check_output("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check_output("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check_output("reset_req0_ready", 32'(req0_ready), 32'd0);
        check_output("reset_alu_op1", alu_operand_1, 32'd0);
        check_output("reset_alu_ctrl", 32'(alu_control), 32'd0);
        check_output("reset_rsp_result", rsp_result, 32'd0);
        rst = 1'b0;
        step();

        // Single-cycle add from requester 0
        $display("[TB] add 5+7 on port 0");
        req0_valid = 1'b1; req0_operand_1 = 32'd5; req0_operand_2 = 32'd7; req0_control = C_ADD;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check_output("add_req0_ready", 32'(req0_ready), 32'd1);
        check_output("add_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        check_output("add_alu_op1", alu_operand_1, 32'd5);
        check_output("add_alu_op2", alu_operand_2, 32'd7);
        check_output("add_alu_ctrl", 32'(alu_control), 32'(C_ADD));
        check_output("add_rsp0_early", 32'(rsp0_valid), 32'd0);
        step();
        check_output("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check_output("add_rsp_result", rsp_result, 32'd12);
        check_output("add_rsp1_quiet", 32'(rsp1_valid), 32'd0);
        step();
        check_output("add_rsp0_consumed", 32'(rsp0_valid), 32'd0);

        // Multi-cycle multiply from requester 1
        $display("[TB] mul 6*7 on port 1");
        req1_valid = 1'b1; req1_operand_1 = 32'd6; req1_operand_2 = 32'd7; req1_control = C_MUL;
        #1;
        check_output("mul_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("mul_rsp1_early", 32'(rsp1_valid), 32'd0);
            check_output("mul_alu_op1_held", alu_operand_1, 32'd6);
            check_output("mul_alu_op2_held", alu_operand_2, 32'd7);
            if (i == 1) begin
                req0_valid = 1'b1; req0_operand_1 = 32'd9; req0_control = C_ADD;
                #1;
                check_output("exec_req0_blocked", 32'(req0_ready), 32'd0);
                req0_valid = 1'b0;
            end
            step();
        end
        check_output("mul_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check_output("mul_rsp_result", rsp_result, 32'd42);
        check_output("mul_rsp0_quiet", 32'(rsp0_valid), 32'd0);
        step();

        // Both requesters valid for four back-to-back operations
        $display("[TB] contention, four operations");
        req0_valid = 1'b1; req0_operand_1 = 32'd1;  req0_operand_2 = 32'd1;  req0_control = C_ADD;
        req1_valid = 1'b1; req1_operand_1 = 32'd10; req1_operand_2 = 32'd10; req1_control = C_ADD;
        #1;
        for (int op = 0; op < 4; op++) begin
            waited = 0;
            while (!(req0_ready || req1_ready) && waited < 10) begin
                step();
                waited++;
            end
            check_output("arb_any_ready", 32'(req0_ready || req1_ready), 32'd1);
            if (op > 0) check_output("arb_issue_gap", 32'(waited), 32'd0);
            check_output("arb_grant", 32'(req1_ready), 32'(exp_grant[op]));
            step();
            step();
            check_output("arb_rsp1_valid", 32'(rsp1_valid), 32'(exp_grant[op]));
            check_output("arb_rsp0_valid", 32'(rsp0_valid), 32'(!exp_grant[op]));
            check_output("arb_rsp_result", rsp_result, exp_grant[op] ? 32'd20 : 32'd2);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Response backpressure on port 0 while port 1 waits
        $display("[TB] backpressure on port 0");
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_operand_1 = 32'd20; req0_operand_2 = 32'd5; req0_control = C_SUB;
        #1;
        check_output("bp_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_operand_1 = 32'd12; req1_operand_2 = 32'd10; req1_control = C_AND;
        #1;
        check_output("bp_exec_req1_blocked", 32'(req1_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check_output("bp_rsp0_held", 32'(rsp0_valid), 32'd1);
            check_output("bp_result_held", rsp_result, 32'd15);
            check_output("bp_req1_blocked", 32'(req1_ready), 32'd0);
            check_output("bp_alu_op1_held", alu_operand_1, 32'd20);
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        check_output("bp_release_rsp0", 32'(rsp0_valid), 32'd1);
        check_output("bp_release_req1_blocked", 32'(req1_ready), 32'd0);
        step();
        check_output("bp_rsp0_cleared", 32'(rsp0_valid), 32'd0);
        check_output("bp_req1_accept", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        check_output("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check_output("bp_and_result", rsp_result, 32'd8);
        step();

        // Reset in the middle of a divide
        $display("[TB] reset during divide");
        req0_valid = 1'b1; req0_operand_1 = 32'd100; req0_operand_2 = 32'd7; req0_control = C_DIV;
        #1;
        check_output("div_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("rst_alu_op1", alu_operand_1, 32'd0);
        check_output("rst_alu_op2", alu_operand_2, 32'd0);
        check_output("rst_alu_ctrl", 32'(alu_control), 32'd0);
        check_output("rst_rsp_result", rsp_result, 32'd0);
        check_output("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("rst_no_rsp0", 32'(rsp0_valid), 32'd0);
            check_output("rst_no_rsp1", 32'(rsp1_valid), 32'd0);
        end

        // Divide after reset completes normally
        req0_valid = 1'b1;
        #1;
        check_output("div2_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("div2_rsp0_early", 32'(rsp0_valid), 32'd0);
            step();
        end
        check_output("div2_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check_output("div2_result", rsp_result, 32'd14);
        step();
        check_output("div2_consumed", 32'(rsp0_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
